// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of a single-port RAM
// with registered one-cycle read latency. Port 0 is instruction fetch and
// port 1 is load/store. Every granted access walks IDLE -> ACCESS -> WAIT ->
// DONE, so the read and write strobes are never high together.
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic              gnt, gnt_nxt;
  logic              last_grant, last_grant_nxt;
  logic              is_rd, is_rd_nxt;
  logic              pick;
  logic              ram_read_nxt, ram_write_nxt;
  logic              ack0_nxt, ack1_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [DATA_W-1:0] ram_data_in_nxt;
  logic [DATA_W-1:0] rdata0_nxt, rdata1_nxt;

  assign busy = (state != IDLE);

  // Next-state and next-output decode; every registered value holds by default.
  always_comb begin
    state_nxt       = state;
    gnt_nxt         = gnt;
    last_grant_nxt  = last_grant;
    is_rd_nxt       = is_rd;
    pick            = 1'b0;
    ram_read_nxt    = ram_read;
    ram_write_nxt   = ram_write;
    ram_addr_nxt    = ram_addr;
    ram_data_in_nxt = ram_data_in;
    ack0_nxt        = ack0;
    ack1_nxt        = ack1;
    rdata0_nxt      = rdata0;
    rdata1_nxt      = rdata1;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that did not win last time takes the RAM.
          pick            = (req0 && req1) ? ~last_grant : req1;
          gnt_nxt         = pick;
          last_grant_nxt  = pick;
          ram_addr_nxt    = pick ? addr1 : addr0;
          ram_data_in_nxt = pick ? wdata1 : wdata0;
          is_rd_nxt       = pick ? ~we1 : ~we0;
          ram_read_nxt    = pick ? ~we1 : ~we0;
          ram_write_nxt   = pick ? we1 : we0;
          state_nxt       = ACCESS;
        end
      end
      ACCESS: begin
        // RAM samples the strobe at the edge closing this cycle.
        ram_read_nxt  = 1'b0;
        ram_write_nxt = 1'b0;
        state_nxt     = WAIT;
      end
      WAIT: begin
        // Registered read data is valid now; capture it into the granted port.
        if (is_rd) begin
          if (gnt) rdata1_nxt = ram_data_out;
          else     rdata0_nxt = ram_data_out;
        end
        ack0_nxt  = ~gnt;
        ack1_nxt  = gnt;
        state_nxt = DONE;
      end
      DONE: begin
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, grant bookkeeping, strobes and acks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      is_rd      <= 1'b0;
      ram_read   <= 1'b0;
      ram_write  <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      last_grant <= last_grant_nxt;
      is_rd      <= is_rd_nxt;
      ram_read   <= ram_read_nxt;
      ram_write  <= ram_write_nxt;
      ack0       <= ack0_nxt;
      ack1       <= ack1_nxt;
    end
  end

  // Data registers: RAM address/write data and the per-port read holding regs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_addr    <= '0;
      ram_data_in <= '0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      ram_addr    <= ram_addr_nxt;
      ram_data_in <= ram_data_in_nxt;
      rdata0      <= rdata0_nxt;
      rdata1      <= rdata1_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural 512x32 RAM that has
// a registered one-cycle read.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [8:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, busy, ram_read, ram_write;
  logic [31:0] rdata0, rdata1;
  logic [8:0]  ram_addr;
  logic [31:0] ram_data_in, ram_data_out;
  logic        preload;

  logic [31:0] mem [0:511];
  int          n_checks = 0;
  int          n_err = 0;
  int          viol = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .busy(busy), .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // RAM model with known contents at a few addresses
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      mem[9'h000] <= 32'hA5A50000;
      mem[9'h1FF] <= 32'h5A5A01FF;
      mem[9'h020] <= 32'h0BAD0020;
    end else begin
      if (ram_write) mem[ram_addr] <= ram_data_in;
      if (ram_read)  ram_data_out <= mem[ram_addr];
    end
  end

  // Strobe and ack overlap monitor
  always @(negedge clk) begin
    if (reset) begin
      if (ram_read && ram_write) viol++;
      if (ack0 && ack1) viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop(input logic p);
    if (p) req1 = 1'b0;
    else   req0 = 1'b0;
  endtask

  // One uncontended access from the IDLE cycle through the return to IDLE.
  task automatic run_txn(input logic p, input logic w, input logic [8:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd, input logic early);
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    tick();
    check("strobe_rd", 32'(ram_read), 32'(!w));
    check("strobe_wr", 32'(ram_write), 32'(w));
    check("ram_addr", 32'(ram_addr), 32'(a));
    if (w) check("ram_data_in", ram_data_in, d);
    check("busy_hi", 32'(busy), 32'd1);
    if (early) drop(p);
    tick();
    check("strobe_off", 32'(ram_read | ram_write), 32'd0);
    check("ack_early", 32'({ack1, ack0}), 32'd0);
    tick();
    check("ack", 32'({ack1, ack0}), p ? 32'd2 : 32'd1);
    if (!w) check("rdata", p ? rdata1 : rdata0, exp_rd);
    drop(p);
    tick();
    check("ack_clear", 32'({ack1, ack0}), 32'd0);
    check("busy_lo", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [1:0] acc;
    logic       e0, e1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    reset = 1'b0;
    preload = 1'b1;
    repeat (2) tick();
    check("rst_ram_read", 32'(ram_read), 32'd0);
    check("rst_ram_write", 32'(ram_write), 32'd0);
    check("rst_acks", 32'({ack1, ack0}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_data_in", ram_data_in, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    preload = 1'b0;
    reset = 1'b1;
    tick();

    // Port 0 write then read-back
    run_txn(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0);
    run_txn(1'b0, 1'b0, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0);
    check("rdata1_untouched", rdata1, 32'd0);

    // Contention after reset: grants 0,1,0,1,0, one ack every 4 cycles
    reset = 1'b0; #2; reset = 1'b1;
    req0 = 1; we0 = 0; addr0 = 9'h000;
    req1 = 1; we1 = 0; addr1 = 9'h1FF;
    for (int k = 1; k <= 20; k++) begin
      tick();
      e0 = (k % 4 == 3) && ((k / 4) % 2 == 0) && (k < 20);
      e1 = (k % 4 == 3) && ((k / 4) % 2 == 1);
      check("cont_ack", 32'({ack1, ack0}), 32'({e1, e0}));
      if (e0) check("cont_rdata0", rdata0, 32'hA5A50000);
      if (e1) check("cont_rdata1", rdata1, 32'h5A5A01FF);
      if (k == 19) begin req0 = 0; req1 = 0; end
    end
    check("cont_idle", 32'(busy), 32'd0);

    // Mixed traffic: port 0 was last, so port 1 write goes first
    req1 = 1; we1 = 1; addr1 = 9'h1FF; wdata1 = 32'h12345678;
    req0 = 1; we0 = 0; addr0 = 9'h1FF;
    tick();
    check("mix_wr_strobe", 32'({ram_read, ram_write}), 32'd1);
    check("mix_wr_addr", 32'(ram_addr), 32'h1FF);
    check("mix_wr_data", ram_data_in, 32'h12345678);
    tick(); tick();
    check("mix_ack1", 32'({ack1, ack0}), 32'd2);
    req1 = 0;
    tick();
    check("mix_gap", 32'({ack1, ack0}), 32'd0);
    tick();
    check("mix_rd_strobe", 32'({ram_read, ram_write}), 32'd2);
    tick(); tick();
    check("mix_ack0", 32'({ack1, ack0}), 32'd1);
    check("mix_rdata0", rdata0, 32'h12345678);
    req0 = 0;
    tick();
    check("mix_idle", 32'(busy), 32'd0);

    // Reset during ACCESS of a write aborts it
    req0 = 1; we0 = 1; addr0 = 9'h020; wdata0 = 32'hCAFEF00D;
    tick();
    check("abort_pre_wr", 32'(ram_write), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_wr_off", 32'(ram_write), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    req0 = 0;
    tick();
    check("abort_held_busy", 32'(busy), 32'd0);
    check("abort_held_ack", 32'({ack1, ack0}), 32'd0);
    #2; reset = 1'b1;
    acc = 2'b00;
    repeat (4) begin tick(); acc = acc | {ack1, ack0}; end
    check("abort_no_ack", 32'(acc), 32'd0);
    run_txn(1'b0, 1'b0, 9'h020, 32'h0, 32'h0BAD0020, 1'b0);

    // Hold check on port 1
    run_txn(1'b1, 1'b0, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0);
    run_txn(1'b1, 1'b1, 9'h011, 32'h11111111, 32'h0, 1'b0);
    check("hold_rdata1", rdata1, 32'hDEADBEEF);
    check("hold_rdata0", rdata0, 32'h0BAD0020);

    // Request dropped before ack still completes
    run_txn(1'b0, 1'b0, 9'h000, 32'h0, 32'hA5A50000, 1'b1);

    check("no_overlap", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
